aes_key_sched: RTL

Sequential, parametrised AES key schedule supporting 128/192/256-bit keys. Generates one 32-bit schedule word per cycle into an internal round-key buffer, then serves any round key by index through a registered read port. Sits between the key-load register and the round datapath of the serial-link security wrapper, replacing per-round combinational expansion.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_ks_subword.sv | 22 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the key schedule: word type, GF(2^8) arithmetic,
// S-box function, InvMixColumns on one column and the round-count helper.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Number of cipher rounds for a given key length.
    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = p ^ (b[k] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (a^254, with 0 -> 0) then affine map.
    function automatic logic [7:0] sbox_fn(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // InvMixColumns applied to one 32-bit column, byte 0 in the MSBs.
    function automatic word_t inv_mix_col(input word_t c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_ks_subword.sv
// SubWord with optional RotWord in front; one instance serves both the
// i mod NK == 0 step (rot_i=1) and the 256-bit i mod 8 == 4 step (rot_i=0).
module aes_ks_subword
    import aes_pkg::*;
(
    input  word_t word_i,
    input  logic  rot_i,
    output word_t word_o
);

    word_t sb_in_s;

    assign sb_in_s = rot_i ? {word_i[23:0], word_i[31:24]} : word_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sb_in_s[8*b +: 8]),
            .out_o (word_o[8*b +: 8])
        );
    end

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_fn(in_i);

endmodule

// File: rtl/aes_key_sched.sv
// Sequential AES key schedule (128/192/256-bit keys): one schedule word per
// cycle into a round-key buffer, then a registered 128-bit round-key read port.
// Optional feature macro: AES_KS_INV_EN adds decryption-order reads with
// InvMixColumns applied to the inner round keys.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rd_idx,
    input  logic                rd_dec,
    output logic [127:0]        rd_key
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);
    localparam int IW = 6;

    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_EXPAND = 1'b1;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
    end

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    j_q, j_d;          // i mod NK, kept as a counter to avoid dividing by 6
    logic [7:0]    rcon_q, rcon_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [127:0]  rd_key_q, rd_key_d;
    logic          load_s;
    logic          wr_en_s;

    word_t w_q [NW];
    word_t prev_s;
    word_t sub_s;
    word_t t_s;
    word_t new_word_s;

    // Generation datapath: t from w[i-1], optionally rotated/substituted.
    assign prev_s = w_q[i_q - IW'(1)];

    aes_ks_subword u_subword (
        .word_i (prev_s),
        .rot_i  (j_q == 3'd0),
        .word_o (sub_s)
    );

    // Select the transformed t for the current schedule position.
    always_comb begin
        t_s = prev_s;
        if (j_q == 3'd0) begin
            t_s = sub_s ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            t_s = sub_s;
        end else begin
            t_s = prev_s;
        end
    end

    assign new_word_s = w_q[i_q - IW'(NK)] ^ t_s;

    // Control FSM next-state: load on start in IDLE, one word per EXPAND cycle.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        load_s  = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    i_d     = IW'(NK);
                    j_d     = 3'd0;
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_EXPAND;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_EXPAND: begin
                wr_en_s = 1'b1;
                if (j_q == 3'(NK - 1)) begin
                    j_d = 3'd0;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (i_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Round-key buffer: no reset needed, keys_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (load_s) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
            end
        end else if (wr_en_s) begin
            w_q[i_q] <= new_word_s;
        end
    end

    logic          hit_s;
    logic [3:0]    r_s;
    logic [IW-1:0] base_s;
    logic [127:0]  blk_s;
`ifdef AES_KS_INV_EN
    logic          inv_s;
`else
    logic          unused_rd_dec_s;
    assign unused_rd_dec_s = rd_dec;
`endif

    // Read port next value: block select, range/valid masking, optional InvMixColumns.
    always_comb begin
        r_s = rd_idx;
`ifdef AES_KS_INV_EN
        inv_s = 1'b0;
        if (rd_dec) begin
            r_s   = 4'(NR) - rd_idx;
            inv_s = (rd_idx != 4'd0) && (rd_idx < 4'(NR));
        end else begin
            r_s = rd_idx;
        end
`endif
        hit_s  = valid_q && (rd_idx <= 4'(NR));
        base_s = hit_s ? {r_s, 2'b00} : '0;
        blk_s  = {w_q[base_s], w_q[base_s + IW'(1)], w_q[base_s + IW'(2)], w_q[base_s + IW'(3)]};
        if (!hit_s) begin
            rd_key_d = 128'd0;
        end
`ifdef AES_KS_INV_EN
        else if (inv_s) begin
            rd_key_d = {inv_mix_col(blk_s[127:96]), inv_mix_col(blk_s[95:64]),
                        inv_mix_col(blk_s[63:32]),  inv_mix_col(blk_s[31:0])};
        end
`endif
        else begin
            rd_key_d = blk_s;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_q <= 128'd0;
        end else begin
            rd_key_q <= rd_key_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = valid_q;
    assign rd_key     = rd_key_q;

endmodule
